// File: rtl/trig_step_sequencer_if.sv
// Control/voice bundle for one step-sequencer lane: pattern/tempo in, trig/step status out.
// Optional SEQ_SWING_EN adds the 7-bit swing amount.
interface trig_step_sequencer_if #(
  parameter int unsigned NUM_STEPS = 16,
  parameter int unsigned DIV_BITS  = 24,
  parameter int unsigned GATE_BITS = 16
);
  localparam int unsigned IDX_W = $clog2(NUM_STEPS);

  logic                 run;
  logic [NUM_STEPS-1:0] pattern;
  logic [DIV_BITS-1:0]  step_period;
  logic [GATE_BITS-1:0] gate_len;
`ifdef SEQ_SWING_EN
  logic [6:0]           swing;
`endif
  logic                 trig;
  logic [IDX_W-1:0]     step_idx;
  logic                 step_strobe;

  modport master (
`ifdef SEQ_SWING_EN
    output swing,
`endif
    output run, pattern, step_period, gate_len,
    input  trig, step_idx, step_strobe
  );

  modport slave (
`ifdef SEQ_SWING_EN
    input  swing,
`endif
    input  run, pattern, step_period, gate_len,
    output trig, step_idx, step_strobe
  );
endinterface

// File: rtl/trig_step_sequencer.sv
// Pattern step sequencer producing the trig gate for one drum voice at an mclk-derived tempo.
// Optional SEQ_SWING_EN: even steps lengthened and odd steps shortened by (dur*swing)>>8.
module trig_step_sequencer #(
  parameter int unsigned NUM_STEPS = 16,
  parameter int unsigned DIV_BITS  = 24,
  parameter int unsigned GATE_BITS = 16
) (
  input logic                   i_mclk,
  input logic                   i_rst,
  trig_step_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(NUM_STEPS);
`ifdef SEQ_SWING_EN
  localparam int unsigned CNT_W  = DIV_BITS + 1;
  localparam int unsigned PROD_W = DIV_BITS + 7;
`else
  localparam int unsigned CNT_W  = DIV_BITS;
`endif

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_per_cnt, w_per_cnt_nx;
  logic [CNT_W-1:0] r_len, w_len_nx;
  logic [CNT_W-1:0] r_gate, w_gate_nx;
  logic [IDX_W-1:0] r_step_idx, w_idx_nx;
  logic             r_strobe, w_strobe_nx;
  logic             r_trig, w_trig_nx;
  logic             w_start;

  // Values latched when entering a strobe cycle
  logic [IDX_W-1:0] w_adv_idx;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_len_new;
  logic [CNT_W-1:0] w_len_m1;
  logic [CNT_W-1:0] w_gate_ext;
  logic [CNT_W-1:0] w_gate_new;
  logic             w_pat_bit;

  assign w_adv_idx  = (r_state == ST_RUNNING) ? r_step_idx + IDX_W'(1) : '0;
  assign w_dur      = (bus.step_period < DIV_BITS'(4)) ? CNT_W'(4) : CNT_W'(bus.step_period);
  assign w_pat_bit  = bus.pattern[w_adv_idx];
  assign w_gate_ext = CNT_W'(bus.gate_len);
  assign w_len_m1   = w_len_new - CNT_W'(1);
  assign w_gate_new = (w_pat_bit && (|bus.gate_len))
                      ? ((w_gate_ext < w_len_m1) ? w_gate_ext : w_len_m1) : '0;

`ifdef SEQ_SWING_EN
  logic [CNT_W-1:0]  r_s, w_s_nx;
  logic [PROD_W-1:0] w_prod;
  logic [CNT_W-1:0]  w_s_calc;

  assign w_prod    = PROD_W'(w_dur) * PROD_W'(bus.swing);
  assign w_s_calc  = CNT_W'(w_prod >> 8);
  // Even steps stretch by the fresh swing amount; odd steps give the same amount back
  assign w_len_new = (!w_adv_idx[0]) ? w_dur + w_s_calc
                   : ((w_dur > r_s) ? w_dur - r_s : w_dur);
  assign w_s_nx    = (w_start && !w_adv_idx[0]) ? w_s_calc : r_s;

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) r_s <= '0;
    else       r_s <= w_s_nx;
  end
`else
  assign w_len_new = w_dur;
`endif

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_STOPPED;
      r_per_cnt  <= '0;
      r_len      <= '0;
      r_gate     <= '0;
      r_step_idx <= '0;
      r_strobe   <= 1'b0;
      r_trig     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_per_cnt  <= w_per_cnt_nx;
      r_len      <= w_len_nx;
      r_gate     <= w_gate_nx;
      r_step_idx <= w_idx_nx;
      r_strobe   <= w_strobe_nx;
      r_trig     <= w_trig_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_per_cnt_nx = r_per_cnt;
    w_len_nx     = r_len;
    w_gate_nx    = r_gate;
    w_idx_nx     = r_step_idx;
    w_strobe_nx  = 1'b0;
    w_trig_nx    = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        if (bus.run) begin
          w_state_nx = ST_RUNNING;
          w_start    = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (!bus.run) begin
          w_state_nx   = ST_STOPPED;
          w_per_cnt_nx = '0;
          w_len_nx     = '0;
          w_gate_nx    = '0;
          w_idx_nx     = '0;
        end else if (r_per_cnt == r_len - CNT_W'(1)) begin
          w_start = 1'b1;
        end else begin
          w_per_cnt_nx = r_per_cnt + CNT_W'(1);
          w_trig_nx    = (w_per_cnt_nx < r_gate);
        end
      end
      default: w_state_nx = ST_STOPPED;
    endcase
    if (w_start) begin
      w_per_cnt_nx = '0;
      w_idx_nx     = w_adv_idx;
      w_len_nx     = w_len_new;
      w_gate_nx    = w_gate_new;
      w_strobe_nx  = 1'b1;
      w_trig_nx    = (w_gate_new != '0);
    end
  end

  assign bus.trig        = r_trig;
  assign bus.step_idx    = r_step_idx;
  assign bus.step_strobe = r_strobe;
endmodule

// File: tb/tb_trig_step_sequencer.sv
// Self-checking bench for trig_step_sequencer: table of steady-run vectors plus
// hand sequences for latency, async reset, run stop/restart and (SEQ_SWING_EN) swing.
module tb_trig_step_sequencer;
  localparam int unsigned NS = 16;
  localparam int unsigned DB = 24;
  localparam int unsigned GB = 16;

  logic i_mclk = 1'b0;
  logic i_rst  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 i_mclk = ~i_mclk;

  trig_step_sequencer_if #(.NUM_STEPS(NS), .DIV_BITS(DB), .GATE_BITS(GB)) u_if ();

  trig_step_sequencer #(.NUM_STEPS(NS), .DIV_BITS(DB), .GATE_BITS(GB)) u_dut (
    .i_mclk (i_mclk),
    .i_rst  (i_rst),
    .bus    (u_if.slave)
  );

  typedef struct {
    logic [NS-1:0] pattern;
    logic [DB-1:0] period;
    logic [GB-1:0] gate;
    int            cycles;
    int            exp_strobes;
    int            exp_high;
    int            exp_rise;
    int            exp_last_idx;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_mclk);
    i_rst    = 1'b1;
    u_if.run = 1'b0;
    @(negedge i_mclk);
    @(negedge i_mclk);
    i_rst    = 1'b0;
  endtask

  task automatic set_inputs(input logic [NS-1:0] pat, input logic [DB-1:0] per,
                            input logic [GB-1:0] gl);
    u_if.pattern     = pat;
    u_if.step_period = per;
    u_if.gate_len    = gl;
`ifdef SEQ_SWING_EN
    u_if.swing       = 7'd0;
`endif
  endtask

  initial begin
    int strobes, high, rise, idx_err, last_idx;
    logic prev_trig;

    //            pattern   period  gate   cyc  strb high rise last
    vecs[0] = '{16'h0001, 24'd100, 16'd10,   3200, 32,  20,  2, 15};
    vecs[1] = '{16'hFFFF, 24'd20,  16'd1000,  200, 10, 190, 10,  9};
    vecs[2] = '{16'hFFFF, 24'd1,   16'd2,      40, 10,  20, 10,  9};
    vecs[3] = '{16'hFFFF, 24'd10,  16'd0,      50,  5,   0,  0,  4};
    vecs[4] = '{16'hAAAA, 24'd8,   16'd3,      64,  8,  12,  4,  7};
    vecs[5] = '{16'h5555, 24'd4,   16'd100,    32,  8,  12,  4,  7};
    vecs[6] = '{16'hFFFF, 24'd3,   16'd1,      16,  4,   4,  4,  3};

    u_if.run = 1'b0;
    set_inputs(16'h0001, 24'd100, 16'd10);

    // Reset values and STOPPED hold with run low
    #2;
    check("rst_trig", longint'(u_if.trig), 0);
    check("rst_idx", longint'(u_if.step_idx), 0);
    check("rst_strobe", longint'(u_if.step_strobe), 0);
    i_rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_mclk);
      if (u_if.step_strobe || u_if.trig) strobes++;
    end
    check("stopped_hold", strobes, 0);

    // Table vectors: steady run, count strobes / trig-high cycles / rising edges
    foreach (vecs[v]) begin
      do_reset();
      set_inputs(vecs[v].pattern, vecs[v].period, vecs[v].gate);
      u_if.run = 1'b1;
      strobes = 0; high = 0; rise = 0; idx_err = 0; last_idx = 0;
      prev_trig = 1'b0;
      for (int k = 0; k < vecs[v].cycles; k++) begin
        @(negedge i_mclk);
        if (u_if.step_strobe) begin
          if (int'(u_if.step_idx) != (strobes % NS)) idx_err++;
          strobes++;
        end
        if (u_if.trig) high++;
        if (u_if.trig && !prev_trig) rise++;
        prev_trig = u_if.trig;
        last_idx  = int'(u_if.step_idx);
      end
      check($sformatf("vec%0d_strobes", v), strobes, vecs[v].exp_strobes);
      check($sformatf("vec%0d_trig_high", v), high, vecs[v].exp_high);
      check($sformatf("vec%0d_rising", v), rise, vecs[v].exp_rise);
      check($sformatf("vec%0d_last_idx", v), last_idx, vecs[v].exp_last_idx);
      check($sformatf("vec%0d_idx_seq_errs", v), idx_err, 0);
    end

    // Start latency: one edge after run is sampled
    do_reset();
    set_inputs(16'h0001, 24'd100, 16'd10);
    u_if.run = 1'b1;
    @(negedge i_mclk);
    check("start_strobe", longint'(u_if.step_strobe), 1);
    check("start_idx", longint'(u_if.step_idx), 0);
    check("start_trig", longint'(u_if.trig), 1);
    @(negedge i_mclk);
    check("start_strobe_one_cycle", longint'(u_if.step_strobe), 0);

    // Async reset in step 5 mid-gate
    do_reset();
    set_inputs(16'h0020, 24'd20, 16'd10);
    u_if.run = 1'b1;
    for (int k = 0; k < 103; k++) @(negedge i_mclk);
    check("pre_rst_idx", longint'(u_if.step_idx), 5);
    check("pre_rst_trig", longint'(u_if.trig), 1);
    #1 i_rst = 1'b1;
    #1;
    check("async_rst_trig", longint'(u_if.trig), 0);
    check("async_rst_idx", longint'(u_if.step_idx), 0);
    check("async_rst_strobe", longint'(u_if.step_strobe), 0);
    @(negedge i_mclk);
    i_rst = 1'b0;
    @(negedge i_mclk);
    check("post_rst_strobe", longint'(u_if.step_strobe), 1);
    check("post_rst_idx", longint'(u_if.step_idx), 0);
    check("post_rst_trig", longint'(u_if.trig), 0);

    // run drop at step 7 mid-gate, then restart
    do_reset();
    set_inputs(16'hFFFF, 24'd10, 16'd5);
    u_if.run = 1'b1;
    for (int k = 0; k < 73; k++) @(negedge i_mclk);
    check("pre_stop_idx", longint'(u_if.step_idx), 7);
    check("pre_stop_trig", longint'(u_if.trig), 1);
    u_if.run = 1'b0;
    @(negedge i_mclk);
    check("stop_trig", longint'(u_if.trig), 0);
    check("stop_idx", longint'(u_if.step_idx), 0);
    check("stop_strobe", longint'(u_if.step_strobe), 0);
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_mclk);
      if (u_if.step_strobe || u_if.trig) strobes++;
    end
    check("stopped_no_activity", strobes, 0);
    u_if.run = 1'b1;
    @(negedge i_mclk);
    check("restart_strobe", longint'(u_if.step_strobe), 1);
    check("restart_idx", longint'(u_if.step_idx), 0);
    check("restart_trig", longint'(u_if.trig), 1);

`ifdef SEQ_SWING_EN
    // Swing 64 at period 100: intervals alternate 125 / 75
    begin
      int pos [5];
      int np;
      int exp_iv [4];
      exp_iv = '{125, 75, 125, 75};
      do_reset();
      set_inputs(16'h0000, 24'd100, 16'd10);
      u_if.swing = 7'd64;
      u_if.run   = 1'b1;
      np = 0;
      for (int k = 0; k < 600 && np < 5; k++) begin
        @(negedge i_mclk);
        if (u_if.step_strobe) begin
          pos[np] = k;
          np++;
        end
      end
      check("swing_strobe_count", np, 5);
      if (np == 5)
        for (int j = 0; j < 4; j++)
          check($sformatf("swing_interval%0d", j), pos[j+1] - pos[j], exp_iv[j]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
